uart_rx_cfg: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 37 +++
 rtl/uart_rx_cfg.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver family:
// parity mode codes, receive FSM states and the expected-parity helper.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK_WAIT
   } t_rx_state;

   // Payload is zero-extended to 9 bits; unused upper bits do not affect the XOR.
   function automatic logic f_parity(input logic [8:0] data, input int mode);
      return (^data) ^ (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RX front end: 2-flop synchronizer, falling-edge detect and majority vote; 2-cycle latency.
// No backpressure: samples are taken whenever i_Sample pulses.
module uart_rx_sync (
   input  logic i_Clock,
   input  logic i_Rst_L,
   input  logic i_RX_Serial,
   input  logic i_Sample,
   output logic o_RX,
   output logic o_Fall,
   output logic o_Majority
);

   logic       rx_meta;
   logic       rx_sync;
   logic       rx_prev;
   logic [1:0] samp;

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
         samp    <= 2'b11;
      end else begin
         rx_meta <= i_RX_Serial;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         if (i_Sample) samp <= {samp[0], rx_sync};
      end
   end

   // The third sample is the live value, so the vote is ready on the last sample cycle.
   assign o_RX       = rx_sync;
   assign o_Fall     = rx_prev & ~rx_sync;
   assign o_Majority = (samp[1] & samp[0]) | ((samp[1] | samp[0]) & rx_sync);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with parity, stop-bit count, false-start and break handling.
// o_RX_DV fires M+1 cycles into the final stop bit; no backpressure, frames are never held.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Rst_L,
   input  logic                 i_RX_Serial,
   output logic                 o_RX_DV,
   output logic [DATA_BITS-1:0] o_RX_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Break,
   output logic                 o_Busy
);

   localparam int              CW        = $clog2(CLKS_PER_BIT);
   localparam int              IW        = $clog2(DATA_BITS);
   localparam int              M         = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0]   CNT_FIRST = CW'(M - 1);
   localparam logic [CW-1:0]   CNT_MID   = CW'(M + 1);
   localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0]   IDX_LAST  = IW'(DATA_BITS - 1);
   localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

   t_rx_state            state, state_nxt;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        bit_idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit, par_err, fr_err;
   logic                 rx, fall, maj;
   logic                 in_frame, sample_en, at_mid, at_end, is_break;
   logic                 cnt_clr, dv_set, brk_set, brk_clr;

   uart_rx_sync u_sync (
      .i_Clock     (i_Clock),
      .i_Rst_L     (i_Rst_L),
      .i_RX_Serial (i_RX_Serial),
      .i_Sample    (sample_en),
      .o_RX        (rx),
      .o_Fall      (fall),
      .o_Majority  (maj)
   );

   assign at_mid    = (cnt == CNT_MID);
   assign at_end    = (cnt == CNT_LAST);
   assign in_frame  = state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
   assign sample_en = in_frame && (cnt >= CNT_FIRST) && (cnt <= CNT_MID);
   // par_bit stays 0 without parity, so it never masks a break.
   assign is_break  = !stop_idx && !maj && (shreg == '0) && !par_bit;
   assign o_Busy    = (state != ST_IDLE);

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      dv_set    = 1'b0;
      brk_set   = 1'b0;
      brk_clr   = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (fall) state_nxt = ST_START;
         end
         ST_START: begin
            if (at_mid && maj) begin
               cnt_clr   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (at_end) begin
               cnt_clr   = 1'b1;
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (at_end) begin
               cnt_clr = 1'b1;
               if (bit_idx == IDX_LAST)
                  state_nxt = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (at_end) begin
               cnt_clr   = 1'b1;
               state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            // Leave mid-bit so a back-to-back start edge is seen from IDLE.
            if (at_mid && is_break) begin
               dv_set    = 1'b1;
               brk_set   = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = ST_BREAK_WAIT;
            end else if (at_mid && (stop_idx == STOP_LAST)) begin
               dv_set    = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (at_end) begin
               cnt_clr = 1'b1;
            end
         end
         ST_BREAK_WAIT: begin
            if (!rx) begin
               cnt_clr = 1'b1;
            end else if (at_end) begin
               cnt_clr   = 1'b1;
               brk_clr   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         cnt          <= '0;
         bit_idx      <= '0;
         stop_idx     <= 1'b0;
         shreg        <= '0;
         par_bit      <= 1'b0;
         par_err      <= 1'b0;
         fr_err       <= 1'b0;
         o_RX_DV      <= 1'b0;
         o_RX_Byte    <= '0;
         o_Parity_Err <= 1'b0;
         o_Frame_Err  <= 1'b0;
         o_Break      <= 1'b0;
      end else begin
         o_RX_DV <= dv_set;
         cnt     <= cnt_clr ? '0 : cnt + 1'b1;
         if (state == ST_IDLE && fall) begin
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_bit  <= 1'b0;
            par_err  <= 1'b0;
            fr_err   <= 1'b0;
         end
         if (at_mid) begin
            case (state)
               ST_DATA:   shreg <= {maj, shreg[DATA_BITS-1:1]};
               ST_PARITY: begin
                  par_bit <= maj;
                  par_err <= (maj != f_parity(9'(shreg), PARITY_MODE));
               end
               ST_STOP:   if (!maj) fr_err <= 1'b1;
               default:   ;
            endcase
         end
         if (state == ST_DATA && at_end) bit_idx <= bit_idx + 1'b1;
         if (state == ST_STOP && at_end) stop_idx <= 1'b1;
         if (dv_set) begin
            o_RX_Byte    <= shreg;
            o_Parity_Err <= par_err;
            o_Frame_Err  <= fr_err | ~maj;
         end
         if (brk_set)      o_Break <= 1'b1;
         else if (brk_clr) o_Break <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 8E1 and 7O2 instances share one clock and reset,
// expected frames are queued as the line is driven and checked when o_RX_DV fires.
module tb_uart_rx_cfg;

   localparam int CPB = 217;

   typedef struct packed {
      logic [8:0] b;
      logic       pe;
      logic       fe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       line_a = 1'b1, line_b = 1'b1, line_c = 1'b1;
   logic       dv_a, dv_b, dv_c;
   logic [7:0] byte_a, byte_b;
   logic [6:0] byte_c;
   logic       pe_a, pe_b, pe_c, fe_a, fe_b, fe_c;
   logic       brk_a, brk_b, brk_c, busy_a, busy_b, busy_c;

   int   total = 0;
   int   bad = 0;
   int   dv_cnt_a = 0;
   exp_t q_a[$], q_b[$], q_c[$];

   always #5 clk = ~clk;

   uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
      .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(line_a), .o_RX_DV(dv_a), .o_RX_Byte(byte_a),
      .o_Parity_Err(pe_a), .o_Frame_Err(fe_a), .o_Break(brk_a), .o_Busy(busy_a));

   uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) dut_b (
      .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(line_b), .o_RX_DV(dv_b), .o_RX_Byte(byte_b),
      .o_Parity_Err(pe_b), .o_Frame_Err(fe_b), .o_Break(brk_b), .o_Busy(busy_b));

   uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) dut_c (
      .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(line_c), .o_RX_DV(dv_c), .o_RX_Byte(byte_c),
      .o_Parity_Err(pe_c), .o_Frame_Err(fe_c), .o_Break(brk_c), .o_Busy(busy_c));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int qsize(input int ln);
      case (ln)
         0:       return q_a.size();
         1:       return q_b.size();
         default: return q_c.size();
      endcase
   endfunction

   task automatic push(input int ln, input logic [8:0] b, input logic pe, input logic fe);
      exp_t e;
      e = '{b: b, pe: pe, fe: fe};
      case (ln)
         0:       q_a.push_back(e);
         1:       q_b.push_back(e);
         default: q_c.push_back(e);
      endcase
   endtask

   task automatic drive(input int ln, input logic v, input int n);
      case (ln)
         0:       line_a = v;
         1:       line_b = v;
         default: line_c = v;
      endcase
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input int ln, input logic [8:0] data, input int nd, input int pmode,
                             input int nstop, input int par_force, input logic stop2_low);
      logic pb;
      drive(ln, 1'b0, CPB);
      for (int i = 0; i < nd; i++) drive(ln, data[i], CPB);
      if (pmode != 0) begin
         pb = (^data) ^ (pmode == 1);
         if (par_force >= 0) pb = par_force[0];
         drive(ln, pb, CPB);
      end
      for (int s = 0; s < nstop; s++) drive(ln, (s == 1 && stop2_low) ? 1'b0 : 1'b1, CPB);
   endtask

   task automatic wait_drain(input int ln, input int budget);
      int n = 0;
      while (qsize(ln) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("drain_q%0d", ln), 32'(qsize(ln)), 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (dv_a) begin
         dv_cnt_a++;
         check("a_dv_expected", 32'(q_a.size() > 0), 32'd1);
         if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("a_byte", 32'(byte_a), 32'(e.b));
            check("a_perr", 32'(pe_a), 32'(e.pe));
            check("a_ferr", 32'(fe_a), 32'(e.fe));
         end
      end
      if (dv_b) begin
         check("b_dv_expected", 32'(q_b.size() > 0), 32'd1);
         if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("b_byte", 32'(byte_b), 32'(e.b));
            check("b_perr", 32'(pe_b), 32'(e.pe));
            check("b_ferr", 32'(fe_b), 32'(e.fe));
         end
      end
      if (dv_c) begin
         check("c_dv_expected", 32'(q_c.size() > 0), 32'd1);
         if (q_c.size() > 0) begin
            e = q_c.pop_front();
            check("c_byte", 32'(byte_c), 32'(e.b));
            check("c_perr", 32'(pe_c), 32'(e.pe));
            check("c_ferr", 32'(fe_c), 32'(e.fe));
         end
      end
   end

   initial begin
      int dv_before;

      // Reset state
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_dv", 32'(dv_a), 32'd0);
      check("rst_byte", 32'(byte_a), 32'd0);
      check("rst_perr", 32'(pe_a), 32'd0);
      check("rst_ferr", 32'(fe_a), 32'd0);
      check("rst_break", 32'(brk_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);

      // 8N1 clean frame
      push(0, 9'h03F, 1'b0, 1'b0);
      send_frame(0, 9'h03F, 8, 0, 1, -1, 1'b0);
      wait_drain(0, 4 * CPB);
      check("8n1_busy_after", 32'(busy_a), 32'd0);

      // 8E1 with parity bit forced to 0 (correct parity for 0x37 is 1)
      push(1, 9'h037, 1'b1, 1'b0);
      send_frame(1, 9'h037, 8, 2, 1, 0, 1'b0);
      wait_drain(1, 4 * CPB);

      // 7O2 back-to-back, second frame with its second stop bit low
      push(2, 9'h055, 1'b0, 1'b0);
      push(2, 9'h02A, 1'b0, 1'b1);
      send_frame(2, 9'h055, 7, 1, 2, -1, 1'b0);
      send_frame(2, 9'h02A, 7, 1, 2, -1, 1'b1);
      drive(2, 1'b1, CPB);
      wait_drain(2, 4 * CPB);

      // False start: 40 clocks low
      dv_before = dv_cnt_a;
      drive(0, 1'b0, 20);
      check("glitch_busy_mid", 32'(busy_a), 32'd1);
      drive(0, 1'b0, 20);
      drive(0, 1'b1, 2 * CPB);
      check("glitch_busy_after", 32'(busy_a), 32'd0);
      check("glitch_no_dv", 32'(dv_cnt_a), 32'(dv_before));
      check("glitch_byte_held", 32'(byte_a), 32'h3F);

      // Break: 12 bit periods low
      push(0, 9'h000, 1'b0, 1'b1);
      drive(0, 1'b0, 11 * CPB);
      check("break_high_low_line", 32'(brk_a), 32'd1);
      check("break_busy", 32'(busy_a), 32'd1);
      drive(0, 1'b0, CPB);
      drive(0, 1'b1, 100);
      check("break_held_after_rise", 32'(brk_a), 32'd1);
      drive(0, 1'b1, CPB);
      check("break_cleared", 32'(brk_a), 32'd0);
      check("break_busy_cleared", 32'(busy_a), 32'd0);
      wait_drain(0, 4 * CPB);

      push(0, 9'h0A5, 1'b0, 1'b0);
      send_frame(0, 9'h0A5, 8, 0, 1, -1, 1'b0);
      wait_drain(0, 4 * CPB);

      // Reset during data bit 3 of 0x3F
      dv_before = dv_cnt_a;
      drive(0, 1'b0, CPB);
      for (int i = 0; i < 3; i++) drive(0, 1'b1, CPB);
      drive(0, 1'b1, 100);
      check("pre_rst_busy", 32'(busy_a), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_byte", 32'(byte_a), 32'd0);
      check("midrst_busy", 32'(busy_a), 32'd0);
      check("midrst_dv", 32'(dv_a), 32'd0);
      check("midrst_ferr", 32'(fe_a), 32'd0);
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      drive(0, 1'b1, 2 * CPB);
      check("midrst_no_dv", 32'(dv_cnt_a), 32'(dv_before));
      check("midrst_idle", 32'(busy_a), 32'd0);
      push(0, 9'h03F, 1'b0, 1'b0);
      send_frame(0, 9'h03F, 8, 0, 1, -1, 1'b0);
      wait_drain(0, 4 * CPB);

      check("b_idle_end", 32'({busy_b, brk_b}), 32'd0);
      check("c_idle_end", 32'({busy_c, brk_c}), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
